// File: rtl/ip_rom_arbiter.sv
// ip_rom_arbiter: shares a single-port boot ROM between a CPU bridge (port 0)
// and a loader engine (port 1). Each access is one n_cs/n_rd strobe, a wait for
// rom_rdata_en (bounded by TIMEOUT), and a one-cycle ack to the granted port.
module ip_rom_arbiter #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              ack0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ack1,
    output logic [7:0]        rdata,
    output logic              err,
    output logic              busy,
    output logic              rom_n_cs,
    output logic              rom_n_rd,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [7:0]        rom_rdata,
    input  logic              rom_rdata_en
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic             last_grant;
    logic             grant;
    logic [CNT_W-1:0] cnt;
    logic             pick1;

    // Round-robin choice: port 1 only if alone, or both request and port 0 went last
    always_comb begin
        pick1 = req1 && (!req0 || (last_grant == 1'b0));
    end

    // Access sequencer with registered ROM strobes, ack, data and status
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            grant       <= 1'b0;
            cnt         <= '0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            rdata       <= '0;
            err         <= 1'b0;
            busy        <= 1'b0;
            rom_n_cs    <= 1'b1;
            rom_n_rd    <= 1'b1;
            rom_address <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    if (req0 || req1) begin
                        grant       <= pick1;
                        last_grant  <= pick1;
                        rom_address <= pick1 ? addr1 : addr0;
                        rom_n_cs    <= 1'b0;
                        rom_n_rd    <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    rom_n_cs <= 1'b1;
                    rom_n_rd <= 1'b1;
                    cnt      <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (rom_rdata_en) begin
                        rdata <= rom_rdata;
                        err   <= 1'b0;
                        ack0  <= ~grant;
                        ack1  <= grant;
                        state <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        rdata <= 8'hFF;
                        err   <= 1'b1;
                        ack0  <= ~grant;
                        ack1  <= grant;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
